// File: rtl/axi4s_counter_source.sv
// AXI4-Stream source emitting a commanded number of beats carrying an incrementing counter.
// Optional random throttling of TVALID is enabled with `define AXI4S_COUNTER_SOURCE_THROTTLE_EN.
module axi4s_counter_source #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [DW-1:0] init,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] beats,
  output logic          TVALID,
  input  logic          TREADY,
  output logic [DW-1:0] TDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_tvalid;
  logic [DW-1:0] r_tdata;
  logic [CW-1:0] r_beats;
  logic [CW-1:0] r_remaining;

  logic          w_handshake;
  logic          w_last_beat;
  logic [DW-1:0] w_tdata_inc;
  logic [CW-1:0] w_beats_inc;
  logic [CW-1:0] w_remaining_dec;

  assign w_handshake     = r_tvalid && TREADY;
  assign w_last_beat     = (r_remaining == CW'(1));
  assign w_tdata_inc     = r_tdata + DW'(1);
  assign w_beats_inc     = r_beats + CW'(1);
  assign w_remaining_dec = r_remaining - CW'(1);

`ifdef AXI4S_COUNTER_SOURCE_THROTTLE_EN
  // Free-running Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifted right.
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_beats     <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_beats <= '0;
            if (len != '0) begin
              r_remaining <= len;
              r_tdata     <= init;
              r_tvalid    <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        RUN: begin
          if (w_handshake) begin
            r_tdata     <= w_tdata_inc;
            r_beats     <= w_beats_inc;
            r_remaining <= w_remaining_dec;
            if (w_last_beat) begin
              r_tvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
`ifdef AXI4S_COUNTER_SOURCE_THROTTLE_EN
            // A zero LFSR bit inserts one idle cycle before the next beat.
            else if (!r_lfsr[0]) begin
              r_tvalid <= 1'b0;
            end
`endif
          end
`ifdef AXI4S_COUNTER_SOURCE_THROTTLE_EN
          else if (!r_tvalid) begin
            r_tvalid <= 1'b1;
          end
`endif
        end

        DONE: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_tvalid <= 1'b0;
          r_state  <= IDLE;
        end

        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_tvalid <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign beats  = r_beats;
  assign TVALID = r_tvalid;
  assign TDATA  = r_tdata;

endmodule

// File: tb/tb_axi4s_counter_source.sv
// Self-checking bench for axi4s_counter_source: beat-level reference model plus directed literals.
module tb_axi4s_counter_source;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef AXI4S_COUNTER_SOURCE_THROTTLE_EN
  localparam bit THROTTLE = 1'b1;
`else
  localparam bit THROTTLE = 1'b0;
`endif

  logic          ACLK    = 1'b0;
  logic          ARESETn = 1'b1;
  logic          start   = 1'b0;
  logic [CW-1:0] len     = '0;
  logic [DW-1:0] init    = '0;
  logic          TREADY  = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] beats;
  logic          TVALID;
  logic [DW-1:0] TDATA;

  int errors = 0;
  int checks = 0;
  int hs_total = 0;
  int done_total = 0;
  bit rand_ready = 1'b0;

  // Reference model: beats still owed, next value owed, beats sent, pending done, pending gap.
  logic [CW-1:0] m_rem = '0;
  logic [DW-1:0] m_data = '0;
  logic [CW-1:0] m_sent = '0;
  logic          m_done_due = 1'b0;
  logic          m_gap = 1'b0;
  logic          m_stall = 1'b0;
  logic [DW-1:0] m_stall_data = '0;
  logic [15:0]   m_lfsr;

  always #5 ACLK = ~ACLK;

  axi4s_counter_source #(.DW(DW), .CW(CW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .start   (start),
    .len     (len),
    .init    (init),
    .busy    (busy),
    .done    (done),
    .beats   (beats),
    .TVALID  (TVALID),
    .TREADY  (TREADY),
    .TDATA   (TDATA)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR value for the edge that follows the current sample point.
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(posedge ACLK) begin
    if (rand_ready) begin
      #1;
      TREADY = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge ACLK) begin
    logic exp_v;
    logic hs;
    logic nd;
    logic ngap;
    if (!ARESETn) begin
      m_rem = '0; m_data = '0; m_sent = '0;
      m_done_due = 1'b0; m_gap = 1'b0; m_stall = 1'b0;
    end else begin
      exp_v = (m_rem != '0) && !m_gap;
      chk("tvalid", TVALID, exp_v);
      chk("busy", busy, m_rem != '0);
      chk("done", done, m_done_due);
      chk("beats", beats, m_sent);
      if (exp_v) chk("tdata", TDATA, m_data);
      if (m_stall) begin
        chk("stall_valid", TVALID, 1'b1);
        chk("stall_data", TDATA, m_stall_data);
      end
      m_stall      = TVALID && !TREADY;
      m_stall_data = TDATA;
      if (TVALID && TREADY) begin
        hs_total++;
        $display("beat data=%08h count=%0d t=%0t", TDATA, beats + 1, $time);
      end
      if (done) done_total++;

      hs   = exp_v && TREADY;
      nd   = 1'b0;
      ngap = 1'b0;
      if (hs) begin
        m_data = m_data + 1;
        m_sent = m_sent + 1;
        if (m_rem == 1) nd = 1'b1;
        else            ngap = THROTTLE && !m_lfsr[0];
        m_rem = m_rem - 1;
      end else if (m_rem == '0 && !m_done_due && start) begin
        m_sent = '0;
        if (len != '0) begin
          m_rem  = len;
          m_data = init;
        end else begin
          nd = 1'b1;
        end
      end
      m_done_due = nd;
      m_gap      = ngap;
    end
  end

  task automatic start_cmd(input logic [CW-1:0] l, input logic [DW-1:0] d);
    @(posedge ACLK); #1;
    start = 1'b1; len = l; init = d;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge ACLK); #2;
      if (m_rem == '0 && !m_done_due) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    int hs_base;
    int dn_base;
    bit reached;

    #2 ARESETn = 1'b0;
    #1;
    chk("rst_tvalid", TVALID, 1'b0);
    chk("rst_tdata", TDATA, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_beats", beats, 16'h0);
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;

    // Back-to-back.
    TREADY = 1'b1;
    hs_base = hs_total; dn_base = done_total;
    start_cmd(16'd4, 32'h10);
`ifndef AXI4S_COUNTER_SOURCE_THROTTLE_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("b2b_valid", TVALID, 1'b1);
      chk("b2b_data", TDATA, 32'h10 + i);
      chk("b2b_busy", busy, 1'b1);
    end
    @(negedge ACLK);
    chk("b2b_done", done, 1'b1);
    chk("b2b_busy_off", busy, 1'b0);
    chk("b2b_beats", beats, 16'd4);
`endif
    wait_idle(100);
    chk("b2b_hs", hs_total - hs_base, 4);
    chk("b2b_done_cnt", done_total - dn_base, 1);

    // Backpressure on beat 2.
    hs_base = hs_total; dn_base = done_total;
    start_cmd(16'd3, 32'h40);
    @(posedge ACLK); #1;
    TREADY = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
`ifndef AXI4S_COUNTER_SOURCE_THROTTLE_EN
      chk("bp_valid", TVALID, 1'b1);
      chk("bp_data", TDATA, 32'h41);
`endif
    end
    @(posedge ACLK); #1;
    TREADY = 1'b1;
    wait_idle(100);
    chk("bp_hs", hs_total - hs_base, 3);
    chk("bp_done_cnt", done_total - dn_base, 1);
    chk("bp_beats", beats, 16'd3);

    // Zero length.
    hs_base = hs_total;
    start_cmd(16'd0, 32'h1234);
    @(negedge ACLK);
    chk("zl_done", done, 1'b1);
    chk("zl_busy", busy, 1'b0);
    chk("zl_valid", TVALID, 1'b0);
    chk("zl_beats", beats, 16'd0);
    wait_idle(20);
    chk("zl_hs", hs_total - hs_base, 0);

    // Wrap.
    hs_base = hs_total;
    start_cmd(16'd3, 32'hFFFF_FFFE);
    @(negedge ACLK);
    chk("wrap_first", TDATA, 32'hFFFF_FFFE);
    wait_idle(100);
    chk("wrap_hs", hs_total - hs_base, 3);
    chk("wrap_tdata_after", TDATA, 32'h0000_0001);

    // Start during RUN is ignored.
    hs_base = hs_total;
    start_cmd(16'd8, 32'h100);
    @(posedge ACLK); #1;
    start = 1'b1; len = 16'd2; init = 32'hAAA;
    @(posedge ACLK); #1;
    start = 1'b0;
    wait_idle(100);
    chk("ign_beats", beats, 16'd8);
    chk("ign_hs", hs_total - hs_base, 8);

    // Asynchronous reset after beat 2 of 8.
    hs_base = hs_total; dn_base = done_total;
    start_cmd(16'd8, 32'h200);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #2;
      if (hs_total - hs_base >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rst_reach", reached, 1'b1);
    #1 ARESETn = 1'b0;
    #1;
    chk("arst_valid", TVALID, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_beats", beats, 16'd0);
    repeat (2) @(posedge ACLK);
    #3 ARESETn = 1'b1;
    start_cmd(16'd2, 32'd5);
    @(negedge ACLK);
    chk("post_rst_first", TDATA, 32'd5);
    wait_idle(100);
    chk("post_rst_done_cnt", done_total - dn_base, 1);
    chk("post_rst_beats", beats, 16'd2);

    // Long command (gaps appear only in the throttled build).
    hs_base = hs_total; dn_base = done_total;
    start_cmd(16'd16, 32'h1000);
    wait_idle(200);
    chk("long_hs", hs_total - hs_base, 16);
    chk("long_done_cnt", done_total - dn_base, 1);
    chk("long_beats", beats, 16'd16);

    // Randomized commands under random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [DW-1:0] d;
      d = $urandom;
      if (n % 5 == 0) d = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      start_cmd(CW'($urandom_range(0, 12)), d);
      wait_idle(400);
    end
    rand_ready = 1'b0;
    @(posedge ACLK); #1;
    TREADY = 1'b1;
    repeat (3) @(posedge ACLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
